// File: rtl/cp0_irq_nest_if.sv
// CP0 access bus between the pipeline and cp0_irq_nest.
// master = pipeline side, slave = CP0 side.
interface cp0_irq_nest_if #(
  parameter int NUM_IRQ = 6
);
  logic               mfc0_flag;
  logic               mtc0_flag;
  logic [31:0]        pc_val;
  logic [4:0]         reg_idx;
  logic [31:0]        wr_data;
  logic               exc_flag;
  logic               eret_flag;
  logic [4:0]         cause_val;
  logic [NUM_IRQ-1:0] irq_in;
  logic [31:0]        rd_data;
  logic [31:0]        status_out;
  logic [31:0]        eaddr_out;
  logic               int_pending;
  logic [2:0]         nest_depth;
  logic               nest_ovf;

  modport master (
    output mfc0_flag, mtc0_flag, pc_val, reg_idx, wr_data,
    output exc_flag, eret_flag, cause_val, irq_in,
    input  rd_data, status_out, eaddr_out,
    input  int_pending, nest_depth, nest_ovf
  );

  modport slave (
    input  mfc0_flag, mtc0_flag, pc_val, reg_idx, wr_data,
    input  exc_flag, eret_flag, cause_val, irq_in,
    output rd_data, status_out, eaddr_out,
    output int_pending, nest_depth, nest_ovf
  );
endinterface

// File: rtl/cp0_irq_nest.sv
// Coprocessor 0 with nested STATUS frame stack,
// external interrupt lines and a Count/Compare timer.
module cp0_irq_nest #(
  parameter int          NUM_IRQ    = 6,
  parameter int          NEST_DEPTH = 4,
  parameter logic [31:0] EXC_VECTOR = 32'h00400004,
  parameter int          COUNT_DIV  = 2
) (
  input logic          clk_sig,
  input logic          rst_sig,
  cp0_irq_nest_if.slave bus
);
  localparam int SW = 5 * NEST_DEPTH;
  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(COUNT_DIV - 1);
  localparam logic [2:0]    DMAX    = 3'(NEST_DEPTH);

  logic [SW-1:0] stack;
  logic [7:0]    im;
  logic [4:0]    exc_code;
  logic [31:0]   epc;
  logic [31:0]   count;
  logic [31:0]   compare;
  logic          ti;
  logic [PW-1:0] pre;
  logic [2:0]    depth;
  logic          ovf;

  logic          tick;
  logic [31:0]   count_nxt;
  logic [7:0]    ip;
  logic [31:0]   status;
  logic [31:0]   rd;
  logic          wr_count, wr_cmp, wr_stat;
  logic          wr_cause, wr_epc;

  assign wr_count = bus.mtc0_flag && (bus.reg_idx == 5'd9);
  assign wr_cmp   = bus.mtc0_flag && (bus.reg_idx == 5'd11);
  assign wr_stat  = bus.mtc0_flag && (bus.reg_idx == 5'd12);
  assign wr_cause = bus.mtc0_flag && (bus.reg_idx == 5'd13);
  assign wr_epc   = bus.mtc0_flag && (bus.reg_idx == 5'd14);

  assign tick = (pre == PRE_MAX);

  always_comb begin
    count_nxt = count;
    if (wr_count)
      count_nxt = bus.wr_data;
    else if (tick)
      count_nxt = count + 32'd1;
  end

  always_comb begin
    ip = '0;
    ip[NUM_IRQ-1:0] = bus.irq_in;
    ip[7] = ti;
  end

  assign status = {im, {(24-SW){1'b0}}, stack};

  always_ff @(posedge clk_sig) begin
    if (!rst_sig) begin
      stack    <= '0;
      im       <= '0;
      exc_code <= '0;
      epc      <= '0;
      count    <= '0;
      compare  <= '0;
      ti       <= 1'b0;
      pre      <= '0;
      depth    <= '0;
      ovf      <= 1'b0;
    end else begin
      count <= count_nxt;
      pre   <= (wr_count || tick) ? '0 : pre + 1'b1;
      // A Compare write both reloads and clears TI, and beats a match.
      if (wr_cmp) begin
        compare <= bus.wr_data;
        ti      <= 1'b0;
      end else if (stack[1] && (count_nxt == compare)) begin
        ti <= 1'b1;
      end
      if (bus.mtc0_flag) begin
        if (wr_stat) begin
          stack <= bus.wr_data[SW-1:0];
          im    <= bus.wr_data[31:24];
          if (bus.wr_data[23])
            ovf <= 1'b0;
        end
        if (wr_cause)
          exc_code <= bus.wr_data[6:2];
        if (wr_epc)
          epc <= bus.wr_data;
      end else if (bus.exc_flag) begin
        stack    <= stack << 5;
        exc_code <= bus.cause_val;
        epc      <= bus.pc_val;
        if (depth == DMAX)
          ovf <= 1'b1;
        else
          depth <= depth + 3'd1;
      end else if (bus.eret_flag) begin
        stack <= stack >> 5;
        if (depth != 3'd0)
          depth <= depth - 3'd1;
      end
    end
  end

  always_comb begin
    rd = '0;
    if (bus.mfc0_flag) begin
      case (bus.reg_idx)
        5'd9:    rd = count;
        5'd11:   rd = compare;
        5'd12:   rd = status;
        5'd13:   rd = {16'h0, ip, 1'b0, exc_code, 2'b00};
        5'd14:   rd = epc;
        default: rd = '0;
      endcase
    end
  end

  assign bus.rd_data     = rd;
  assign bus.status_out  = status;
  assign bus.eaddr_out   = bus.eret_flag ? epc : EXC_VECTOR;
  assign bus.int_pending = stack[0] & |(ip & im);
  assign bus.nest_depth  = depth;
  assign bus.nest_ovf    = ovf;
endmodule
